// File: rtl/char_dispatch.sv
// Character FIFO that broadcasts each head entry to NCH consumers and pops it once all have taken it.
// Optional build macro CHAR_DISPATCH_REPEAT_FILTER_EN drops strobes repeating the last accepted character.
module char_dispatch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int NCH   = 2
) (
  input  logic                     clk_100MHz,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         char_in,
  input  logic                     char_stb,
  output logic [WIDTH-1:0]         ch_data,
  output logic [NCH-1:0]           ch_valid,
  input  logic [NCH-1:0]           ch_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [NCH-1:0]   r_done;
  logic             r_overflow;

  logic             w_full;
  logic             w_nonempty;
  logic [NCH-1:0]   w_valid;
  logic [NCH-1:0]   w_hs;
  logic             w_pop;
  logic             w_filt;
  logic             w_push;
  logic             w_drop;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_nonempty = (r_count != '0);

  // Handshake: channel i transfers on an edge where ch_valid[i] && ch_ready[i];
  // valid never depends on ready, and a done channel stays quiet until the head pops.
  assign w_valid = {NCH{w_nonempty}} & ~r_done;
  assign w_hs    = w_valid & ch_ready;
  assign w_pop   = w_nonempty && (&(r_done | w_hs));

`ifdef CHAR_DISPATCH_REPEAT_FILTER_EN
  logic             r_last_valid;
  logic [WIDTH-1:0] r_last_char;

  assign w_filt = char_stb && r_last_valid && (char_in == r_last_char);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_last_valid <= 1'b0;
      r_last_char  <= '0;
    end else if (w_push) begin
      r_last_valid <= 1'b1;
      r_last_char  <= char_in;
    end
  end
`else
  assign w_filt = 1'b0;
`endif

  // A filtered strobe neither stores nor counts as an overflow drop.
  assign w_push = char_stb && !w_filt && !w_full;
  assign w_drop = char_stb && !w_filt && w_full;

  always_ff @(posedge clk_100MHz) begin
    if (w_push) begin
      r_mem[r_wptr] <= char_in;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_done     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_done <= '0;
      end else begin
        r_done <= r_done | w_hs;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Empty FIFO presents zero rather than stale memory contents.
  assign ch_data  = w_nonempty ? r_mem[r_rptr] : '0;
  assign ch_valid = w_valid;
  assign count    = r_count;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule
